// File: rtl/rs_issue_select.sv
// Round-robin pick of one ready RS entry per cycle, two-stage issue/execute pipeline.
// Broadcasts {index, tag, result} two cycles after issue; the ROB stalls via out_stall, and flush kills in-flight work.
module rs_issue_select #(
  parameter int SIZE  = 8,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [SIZE-1:0]            rs_ready,
  input  logic [SIZE-1:0]            rs_acu,
  input  logic [SIZE-1:0][2:0]       rs_alu_op,
  input  logic [SIZE-1:0][2:0]       rs_cmp_op,
  input  logic [SIZE-1:0][XLEN-1:0]  rs_r1,
  input  logic [SIZE-1:0][XLEN-1:0]  rs_r2,
  input  logic [SIZE-1:0][TAG_W-1:0] rs_tag,
  input  logic                       out_stall,
  output logic [SIZE-1:0]            bc_rdy,
  output logic                       bc_valid,
  output logic [TAG_W-1:0]           bc_tag,
  output logic [XLEN-1:0]            bc_data,
  output logic                       busy
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic              s1_vld_q, s1_vld_d;
  logic [IW-1:0]     s1_idx_q, s1_idx_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic              s1_acu_q, s1_acu_d;
  logic [2:0]        s1_alu_op_q, s1_alu_op_d;
  logic [2:0]        s1_cmp_op_q, s1_cmp_op_d;
  logic [XLEN-1:0]   s1_r1_q, s1_r1_d;
  logic [XLEN-1:0]   s1_r2_q, s1_r2_d;

  logic              s2_vld_q, s2_vld_d;
  logic [IW-1:0]     s2_idx_q, s2_idx_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic [XLEN-1:0]   s2_res_q, s2_res_d;

  logic [SIZE-1:0]   inflight_q, inflight_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [SIZE-1:0]   elig;
  logic              found;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     cand;
  logic              fire, s2_free, s1_move, s1_free, issue;
  logic [XLEN-1:0]   exe_res;

  // First eligible entry at or after rr_ptr, wrapping; in-flight entries are masked out.
  always_comb begin
    elig    = rs_ready & ~inflight_q;
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < SIZE; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % SIZE);
      if (!found && elig[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign fire    = s2_vld_q & ~out_stall & ~flush;
  assign s2_free = ~s2_vld_q | fire;
  assign s1_move = s1_vld_q & s2_free;
  assign s1_free = ~s1_vld_q | s1_move;
  assign issue   = found & ~flush & s1_free;

  always_comb begin
    logic [4:0] shamt;
    logic       lt_s, lt_u, eq, cmp_bit;
    shamt   = s1_r2_q[4:0];
    lt_s    = $signed(s1_r1_q) < $signed(s1_r2_q);
    lt_u    = s1_r1_q < s1_r2_q;
    eq      = s1_r1_q == s1_r2_q;
    cmp_bit = 1'b0;
    exe_res = '0;
    if (s1_acu_q) begin
      case (s1_cmp_op_q)
        3'b000:  cmp_bit = eq;
        3'b001:  cmp_bit = ~eq;
        3'b100:  cmp_bit = lt_s;
        3'b101:  cmp_bit = ~lt_s;
        3'b110:  cmp_bit = lt_u;
        3'b111:  cmp_bit = ~lt_u;
        default: cmp_bit = 1'b0;
      endcase
      exe_res = {{(XLEN-1){1'b0}}, cmp_bit};
    end else begin
      case (s1_alu_op_q)
        3'b000:  exe_res = s1_r1_q + s1_r2_q;
        3'b001:  exe_res = s1_r1_q << shamt;
        3'b010:  exe_res = $signed(s1_r1_q) >>> shamt;
        3'b011:  exe_res = s1_r1_q - s1_r2_q;
        3'b100:  exe_res = s1_r1_q ^ s1_r2_q;
        3'b101:  exe_res = s1_r1_q >> shamt;
        3'b110:  exe_res = s1_r1_q | s1_r2_q;
        default: exe_res = s1_r1_q & s1_r2_q;
      endcase
    end
  end

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_idx_d    = s1_idx_q;
    s1_tag_d    = s1_tag_q;
    s1_acu_d    = s1_acu_q;
    s1_alu_op_d = s1_alu_op_q;
    s1_cmp_op_d = s1_cmp_op_q;
    s1_r1_d     = s1_r1_q;
    s1_r2_d     = s1_r2_q;
    s2_vld_d    = s2_vld_q;
    s2_idx_d    = s2_idx_q;
    s2_tag_d    = s2_tag_q;
    s2_res_d    = s2_res_q;
    inflight_d  = inflight_q;
    rr_ptr_d    = rr_ptr_q;

    if (s1_move) begin
      s2_vld_d = 1'b1;
      s2_idx_d = s1_idx_q;
      s2_tag_d = s1_tag_q;
      s2_res_d = exe_res;
    end else if (fire) begin
      s2_vld_d = 1'b0;
    end

    if (fire) inflight_d[s2_idx_q] = 1'b0;

    if (issue) begin
      s1_vld_d    = 1'b1;
      s1_idx_d    = sel_idx;
      s1_tag_d    = rs_tag[sel_idx];
      s1_acu_d    = rs_acu[sel_idx];
      s1_alu_op_d = rs_alu_op[sel_idx];
      s1_cmp_op_d = rs_cmp_op[sel_idx];
      s1_r1_d     = rs_r1[sel_idx];
      s1_r2_d     = rs_r2[sel_idx];
      inflight_d[sel_idx] = 1'b1;
      rr_ptr_d = (sel_idx == IW'(SIZE-1)) ? '0 : sel_idx + IW'(1);
    end else if (s1_move) begin
      s1_vld_d = 1'b0;
    end

    // Flush keeps rr_ptr so the round-robin order survives a pipeline kill.
    if (flush) begin
      s1_vld_d   = 1'b0;
      s2_vld_d   = 1'b0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_tag_q    <= '0;
      s1_acu_q    <= 1'b0;
      s1_alu_op_q <= '0;
      s1_cmp_op_q <= '0;
      s1_r1_q     <= '0;
      s1_r2_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_idx_q    <= '0;
      s2_tag_q    <= '0;
      s2_res_q    <= '0;
      inflight_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_idx_q    <= s1_idx_d;
      s1_tag_q    <= s1_tag_d;
      s1_acu_q    <= s1_acu_d;
      s1_alu_op_q <= s1_alu_op_d;
      s1_cmp_op_q <= s1_cmp_op_d;
      s1_r1_q     <= s1_r1_d;
      s1_r2_q     <= s1_r2_d;
      s2_vld_q    <= s2_vld_d;
      s2_idx_q    <= s2_idx_d;
      s2_tag_q    <= s2_tag_d;
      s2_res_q    <= s2_res_d;
      inflight_q  <= inflight_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    bc_rdy = '0;
    if (fire) bc_rdy[s2_idx_q] = 1'b1;
  end

  assign bc_valid = s2_vld_q & ~flush;
  assign bc_tag   = s2_tag_q;
  assign bc_data  = s2_res_q;
  assign busy     = s1_vld_q | s2_vld_q;

endmodule
